// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and |a|<|b| finish in one cycle.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      alucontrol,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  // alucontrol encodings shared with the ALU decoder
  localparam logic [3:0] ALU_DIV  = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;
  localparam logic [3:0] ALU_REM  = 4'b1010;
  localparam logic [3:0] ALU_REMU = 4'b1011;

  localparam int CW = $clog2(XLEN);

  // state | meaning
  // IDLE  | waiting for a divide request
  // CALC  | one restoring step per cycle, XLEN steps
  // FIX   | sign fixup and quotient/remainder select into result
  // DONE  | result valid, done pulses for this cycle
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rem_op_q, rem_op_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_div_op, op_signed, op_rem;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] quo_fix, rem_fix;
`ifdef DIV_EARLY_OUT_EN
  logic            ovf, early_hit;
  logic [XLEN-1:0] early_res;
`endif

  always_comb begin
    is_div_op = (alucontrol == ALU_DIV) || (alucontrol == ALU_DIVU) ||
                (alucontrol == ALU_REM) || (alucontrol == ALU_REMU);
    op_signed = (alucontrol == ALU_DIV) || (alucontrol == ALU_REM);
    op_rem    = (alucontrol == ALU_REM) || (alucontrol == ALU_REMU);
    a_neg     = op_signed & src_a[XLEN-1];
    b_neg     = op_signed & src_b[XLEN-1];
    mag_a     = a_neg ? (~src_a + 1'b1) : src_a;
    mag_b     = b_neg ? (~src_b + 1'b1) : src_b;

    // one extra bit keeps the step correct for divisors >= 2^(XLEN-1)
    shifted   = {rem_q, quo_q[XLEN-1]};
    diff      = {1'b0, shifted} - {2'b00, div_q};

    quo_fix   = dz_q ? '1 : (qneg_q ? (~quo_q + 1'b1) : quo_q);
    rem_fix   = rneg_q ? (~rem_q + 1'b1) : rem_q;

`ifdef DIV_EARLY_OUT_EN
    ovf       = op_signed && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    early_hit = (src_b == '0) || ovf || (mag_a < mag_b);
    if (op_rem)
      early_res = ovf ? '0 : src_a;
    else
      early_res = (src_b == '0) ? '1 : (ovf ? src_a : '0);
`endif

    state_d  = state_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    rem_op_d = rem_op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start && is_div_op && !flush) begin
          rem_op_d = op_rem;
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          dz_d     = (src_b == '0);
          quo_d    = mag_a;
          div_d    = mag_b;
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
`ifdef DIV_EARLY_OUT_EN
          if (early_hit) begin
            result_d = early_res;
            state_d  = DONE;
          end
`endif
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          quo_d = {quo_q[XLEN-2:0], ~diff[XLEN+1]};
          rem_d = diff[XLEN+1] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1))
            state_d = FIX;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          result_d = rem_op_q ? rem_fix : quo_fix;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      rem_op_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      rem_op_q <= rem_op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: signed/unsigned ops, corner cases, start-while-busy, flush, reset.
module tb_div_unit;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_DIV  = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;
  localparam logic [3:0] ALU_REM  = 4'b1010;
  localparam logic [3:0] ALU_REMU = 4'b1011;

`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SP = 1;
`else
  localparam int LAT_SP = 34;
`endif
  localparam int LAT_FULL = 34;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alucontrol = 4'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc = 0;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alucontrol(alucontrol),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; alucontrol = op; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0; alucontrol = ALU_ADD;
  endtask

  task automatic wait_done(output int lat);
    @(negedge clk);
    while (!done && (cyc - acc) < 200) @(negedge clk);
    lat = done ? (cyc - acc + 1) : -1;
  endtask

  task automatic no_done(input string tag, input int n);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(op, a, b);
    wait_done(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, exp);
    @(negedge clk);
    check({tag, "_done_low"}, {31'b0, done}, 32'd0);
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;

    run_op("div_m7_2", ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT_FULL);
    run_op("rem_m7_2", ALU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT_FULL);
    run_op("div_7_m2", ALU_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, LAT_FULL);
    run_op("rem_7_m2", ALU_REM, 32'd7, 32'hFFFFFFFE, 32'd1, LAT_FULL);
    run_op("divu_dz", ALU_DIVU, 32'h80000000, 32'd0, 32'hFFFFFFFF, LAT_SP);
    run_op("remu_dz", ALU_REMU, 32'h80000000, 32'd0, 32'h80000000, LAT_SP);
    run_op("div_dz", ALU_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, LAT_SP);
    run_op("rem_dz", ALU_REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, LAT_SP);
    run_op("div_ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SP);
    run_op("rem_ovf", ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, LAT_SP);
    run_op("div_small", ALU_DIV, 32'hFFFFFFFD, 32'd7, 32'd0, LAT_SP);
    run_op("rem_small", ALU_REM, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFD, LAT_SP);
    run_op("divu_big", ALU_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'd1, LAT_FULL);
    run_op("remu_big", ALU_REMU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, LAT_FULL);

    // non-divide op and start+flush in IDLE are both dropped
    @(negedge clk);
    start = 1'b1; alucontrol = ALU_ADD; src_a = 32'd5; src_b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("nondiv_ignored", {31'b0, busy}, 32'd0);
    start = 1'b1; flush = 1'b1; alucontrol = ALU_DIV;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0; alucontrol = ALU_ADD;
    @(negedge clk);
    check("flush_beats_start", {31'b0, busy}, 32'd0);

    // second start while busy is ignored
    start_op(ALU_DIVU, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("busy_mid_calc", {31'b0, busy}, 32'd1);
    start = 1'b1; alucontrol = ALU_DIV; src_a = 32'd1; src_b = 32'd1;
    @(posedge clk); #1 start = 1'b0; alucontrol = ALU_ADD;
    wait_done(lat);
    check("busy_start_lat", lat, LAT_FULL);
    check("busy_start_res", result, 32'd14);
    no_done("busy_start_single", 40);

    // flush mid-calc: no done, result unchanged
    start_op(ALU_REMU, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result_kept", result, 32'd14);
    no_done("flush_no_done", 40);
    run_op("remu_after_flush", ALU_REMU, 32'd100, 32'd7, 32'd2, LAT_FULL);

    // reset mid-operation
    start_op(ALU_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    no_done("midrst_no_done", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
